// File: rtl/vga_fb_pkg.sv
// ============================================================================
// vga_fb_pkg : shared constants and types for the frame-buffer fetch arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_fb_pkg;

  localparam int SRC_W_DEF         = 192;
  localparam int SRC_H_DEF         = 108;
  localparam int H_REP_DEF         = 10;
  localparam int V_REP_DEF         = 10;
  localparam int DATA_W_DEF        = 24;
  localparam int ADDR_W_DEF        = 15;
  localparam int FIFO_DEPTH_DEF    = 64;
  localparam int HI_WM_DEF         = 48;
  localparam int HOST_MAX_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_fb_fetch_arbiter_fifo.sv
// ============================================================================
// sync_fifo_sa : show-ahead synchronous FIFO with flush and occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_sa
  import vga_fb_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_C) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/vga_fb_fetch_arbiter.sv
// ============================================================================
// vga_fb_fetch_arbiter : frame-buffer RAM sharing between upscaling pixel fetch and host writes
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_fb_fetch_arbiter
  import vga_fb_pkg::*;
#(
  parameter int SRC_W         = SRC_W_DEF,
  parameter int SRC_H         = SRC_H_DEF,
  parameter int H_REP         = H_REP_DEF,
  parameter int V_REP         = V_REP_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int HI_WM         = HI_WM_DEF,
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              host_wr_req,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ack
);

  localparam int XW = cnt_w(SRC_W);
  localparam int YW = cnt_w(SRC_H);
  localparam int VW = cnt_w(V_REP);
  localparam int HW = cnt_w(H_REP);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(HOST_MAX_WAIT + 1);

  localparam logic [XW-1:0]     X_LAST   = XW'(SRC_W - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(SRC_H - 1);
  localparam logic [VW-1:0]     V_LAST   = VW'(V_REP - 1);
  localparam logic [HW-1:0]     H_LAST   = HW'(H_REP - 1);
  localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     HI_WM_C  = CW'(HI_WM);
  localparam logic [WW-1:0]     WAIT_MAX = WW'(HOST_MAX_WAIT);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

  fetch_state_e      state_q;
  logic [XW-1:0]     src_x_q;
  logic [YW-1:0]     src_y_q;
  logic [VW-1:0]     line_rep_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              rd_pend_q;
  logic [HW-1:0]     h_rep_q, h_rep_d;
  logic              underflow_q, underflow_d;
  logic [WW-1:0]     host_wait_q, host_wait_d;

  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fetch_ok, fetch_gnt, host_gnt, host_force, last_rd;
  logic              fifo_push, fifo_pop;

  // Fetch is held off in the frame_start cycle so the first read of a frame
  // always uses the freshly cleared counters.
  assign fetch_ok   = (state_q == ST_FETCH) && !frame_start &&
                      ((fifo_count + CW'(rd_pend_q)) < DEPTH_C);
  assign host_force = (host_wait_q == WAIT_MAX);
  assign fetch_gnt  = !reset && fetch_ok &&
                      (!host_wr_req || ((fifo_count < HI_WM_C) && !host_force));
  assign host_gnt   = !reset && host_wr_req && !fetch_gnt;
  assign last_rd    = (src_x_q == X_LAST) && (line_rep_q == V_LAST) && (src_y_q == Y_LAST);

  assign mem_rd_en   = fetch_gnt;
  assign mem_we      = host_gnt;
  assign host_wr_ack = host_gnt;
  assign mem_addr    = host_gnt  ? host_wr_addr :
                       fetch_gnt ? (row_base_q + ADDR_W'(src_x_q)) : '0;
  assign mem_wdata   = host_gnt ? host_wr_data : '0;

  assign fifo_push = rd_pend_q && !frame_start;
  assign fifo_pop  = pix_rd && !fifo_empty && (h_rep_q == H_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      src_x_q    <= '0;
      src_y_q    <= '0;
      line_rep_q <= '0;
      row_base_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_pend_q <= fetch_gnt;
      if (frame_start) begin
        state_q    <= ST_FETCH;
        src_x_q    <= '0;
        src_y_q    <= '0;
        line_rep_q <= '0;
        row_base_q <= '0;
      end else if (fetch_gnt) begin
        if (last_rd) state_q <= ST_DONE;
        if (src_x_q == X_LAST) begin
          src_x_q <= '0;
          if (line_rep_q == V_LAST) begin
            line_rep_q <= '0;
            src_y_q    <= src_y_q + 1'b1;
            row_base_q <= row_base_q + ROW_STEP;
          end else begin
            line_rep_q <= line_rep_q + 1'b1;
          end
        end else begin
          src_x_q <= src_x_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    h_rep_d     = h_rep_q;
    underflow_d = underflow_q;
    host_wait_d = host_wait_q;
    if (pix_rd) begin
      if (fifo_empty) underflow_d = 1'b1;
      else            h_rep_d     = (h_rep_q == H_LAST) ? '0 : h_rep_q + 1'b1;
    end
    if (frame_start) begin
      h_rep_d     = '0;
      underflow_d = 1'b0;
    end
    if (host_gnt)                                         host_wait_d = '0;
    else if (host_wr_req && (host_wait_q != WAIT_MAX))    host_wait_d = host_wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_rep_q     <= '0;
      underflow_q <= 1'b0;
      host_wait_q <= '0;
    end else begin
      h_rep_q     <= h_rep_d;
      underflow_q <= underflow_d;
      host_wait_q <= host_wait_d;
    end
  end

  sync_fifo_sa #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (frame_start),
    .push_i  (fifo_push),
    .data_i  (mem_rdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign pix_data  = fifo_empty ? '0 : fifo_head;
  assign pix_valid = !fifo_empty;
  assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_fetch_arbiter.sv
// ============================================================================
// tb_vga_fb_fetch_arbiter : directed bench, full-size instance plus a reduced instance
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_fb_fetch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, frame_start, pix_rd, host_wr_req;
  logic [23:0] pix_data, mem_rdata, mem_wdata, host_wr_data;
  logic        pix_valid, underflow, mem_rd_en, mem_we, host_wr_ack;
  logic [14:0] mem_addr, host_wr_addr;

  logic        s_fs, s_rd, s_req;
  logic [23:0] s_pix_data, s_rdata, s_wdata, s_hdata;
  logic        s_pix_valid, s_underflow, s_rd_en, s_we, s_ack;
  logic [7:0]  s_addr, s_haddr;

  logic [23:0] ram   [32768];
  logic [23:0] ram_s [256];

  int n_vec = 0;
  int n_err = 0;
  int excl_viol = 0;

  vga_fb_fetch_arbiter dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .host_wr_req(host_wr_req),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_wr_ack(host_wr_ack)
  );

  vga_fb_fetch_arbiter #(
    .SRC_W(8), .SRC_H(4), .H_REP(1), .V_REP(2), .DATA_W(24), .ADDR_W(8),
    .FIFO_DEPTH(8), .HI_WM(6), .HOST_MAX_WAIT(16)
  ) dut_s (
    .clk(clk), .reset(reset), .frame_start(s_fs), .pix_rd(s_rd),
    .pix_data(s_pix_data), .pix_valid(s_pix_valid), .underflow(s_underflow),
    .mem_addr(s_addr), .mem_rd_en(s_rd_en), .mem_rdata(s_rdata),
    .mem_we(s_we), .mem_wdata(s_wdata), .host_wr_req(s_req),
    .host_wr_addr(s_haddr), .host_wr_data(s_hdata), .host_wr_ack(s_ack)
  );

  function automatic logic [23:0] pix_of(input int a);
    logic [7:0] lo = 8'(a);
    return {lo ^ 8'h5A, 16'(a)};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
    if (mem_we)    ram[mem_addr] <= mem_wdata;
    if (s_rd_en)   s_rdata <= ram_s[s_addr];
    if (s_we)      ram_s[s_addr] <= s_wdata;
  end

  always @(negedge clk) begin
    if ((mem_rd_en && mem_we) || (s_rd_en && s_we)) excl_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got_ack, ack_cyc, s_reads, late, pops, found;
    for (int i = 0; i < 32768; i++) ram[i] = pix_of(i);
    for (int i = 0; i < 256; i++)   ram_s[i] = pix_of(i);
    reset = 1'b1; frame_start = 1'b0; pix_rd = 1'b0; host_wr_req = 1'b0;
    host_wr_addr = '0; host_wr_data = '0;
    s_fs = 1'b0; s_rd = 1'b0; s_req = 1'b0; s_haddr = '0; s_hdata = '0;
    repeat (3) next_cycle();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_pix_valid", pix_valid, 0);
    check_eq("rst_pix_data", pix_data, 0);
    check_eq("rst_underflow", underflow, 0);
    check_eq("rst_rd_en", mem_rd_en, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);

    // Upscaled stream: two output lines, both from source row 0
    next_cycle(); frame_start = 1'b1;
    next_cycle(); frame_start = 1'b0;
    repeat (70) next_cycle();
    pix_rd = 1'b1;
    for (int j = 0; j < 3840; j++) begin
      @(negedge clk);
      check_eq("t1_pix", pix_data, pix_of((j % 1920) / 10));
      next_cycle();
    end
    check_eq("t1_no_underflow", underflow, 0);

    // Host write while FIFO is above the watermark
    pix_rd = 1'b0;
    repeat (5) next_cycle();
    host_wr_req = 1'b1; host_wr_addr = 15'h100; host_wr_data = 24'hABCDEF;
    got_ack = 0;
    for (int c = 0; c < 2 && got_ack == 0; c++) begin
      @(negedge clk);
      if (host_wr_ack) begin
        got_ack = 1;
        check_eq("t2_we", mem_we, 1);
        check_eq("t2_rd_en", mem_rd_en, 0);
        check_eq("t2_addr", mem_addr, 32'h100);
        check_eq("t2_wdata", mem_wdata, 32'hABCDEF);
      end
      next_cycle();
    end
    host_wr_req = 1'b0;
    check_eq("t2_ack_seen", got_ack, 1);
    @(negedge clk);
    check_eq("t2_single_ack", host_wr_ack, 0);

    // Underflow right after frame_start, cleared by the next frame_start
    next_cycle(); frame_start = 1'b1;
    next_cycle(); frame_start = 1'b0; pix_rd = 1'b1;
    @(negedge clk);
    check_eq("t4_pix_data_empty", pix_data, 0);
    check_eq("t4_pix_valid_empty", pix_valid, 0);
    next_cycle(); pix_rd = 1'b0;
    @(negedge clk);
    check_eq("t4_underflow_set", underflow, 1);
    repeat (10) next_cycle();
    check_eq("t4_underflow_sticky", underflow, 1);
    frame_start = 1'b1;
    next_cycle(); frame_start = 1'b0;
    @(negedge clk);
    check_eq("t4_underflow_clr", underflow, 0);

    // frame_start with a read in flight
    repeat (80) next_cycle();
    pix_rd = 1'b1;
    repeat (300) next_cycle();
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (mem_rd_en) found = 1;
      next_cycle();
    end
    check_eq("t5_read_found", found, 1);
    frame_start = 1'b1; pix_rd = 1'b0;
    @(negedge clk);
    check_eq("t5_no_rd_at_fs", mem_rd_en, 0);
    next_cycle(); frame_start = 1'b0;
    @(negedge clk);
    check_eq("t5_first_rd", mem_rd_en, 1);
    check_eq("t5_first_addr", mem_addr, 0);
    check_eq("t5_inflight_dropped", pix_valid, 0);
    repeat (3) next_cycle();
    pix_rd = 1'b1;
    @(negedge clk);
    check_eq("t5_first_pix", pix_data, pix_of(0));
    next_cycle(); pix_rd = 1'b0;

    // Reduced instance: starvation bound and whole-frame read count
    s_fs = 1'b1;
    next_cycle(); s_fs = 1'b0; s_rd = 1'b1;
    s_haddr = 8'd5; s_hdata = pix_of(5);
    ack_cyc = -1; s_reads = 0; late = 0; pops = 0; got_ack = 0;
    for (int c = 0; c < 200; c++) begin
      s_req = (c >= 5) && (got_ack == 0);
      @(negedge clk);
      if (s_rd_en) begin
        s_reads++;
        if (c >= 120) late++;
      end
      if (s_pix_valid) begin
        check_eq("t6_pix", s_pix_data, pix_of((pops / 16) * 8 + (pops % 8)));
        pops++;
      end
      if (s_ack) begin
        got_ack = 1;
        ack_cyc = c - 5;
        check_eq("t3_addr", s_addr, 5);
        check_eq("t3_rd_en", s_rd_en, 0);
      end
      next_cycle();
    end
    s_req = 1'b0; s_rd = 1'b0;
    check_eq("t3_wait_bound", (ack_cyc >= 0) && (ack_cyc <= 17), 1);
    check_eq("t6_read_count", s_reads, 64);
    check_eq("t6_reads_after_done", late, 0);
    check_eq("t6_pop_count", pops, 64);
    check_eq("rd_we_excl", excl_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
